avl_arb2: RTL and testbench

//  Two-master Avalon-MM arbiter sharing the single SDRAM slave between instruction fetch (m0, from core_if)
//  and the load/store unit (m1). Sits between the core bus masters and sdram_sim_model / SDRAM controller.

---
 rtl/avl_pkg.sv | 18 +
 rtl/avl_owner_fifo.sv | 58 +++++
 rtl/avl_arb2.sv | 143 ++++++++++++++
 tb/tb_avl_arb2.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/avl_pkg.sv
// Shared types for the two-master Avalon-MM arbiter.
package avl_pkg;

    // Which master issued a read that is still in flight at the slave.
    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_LSU = 1'b1
    } avl_owner_t;

    localparam int AVL_BE_W   = 4;
    localparam int AVL_DATA_W = 32;

    // The master that is not 'o'; used to advance the round-robin pointer.
    function automatic avl_owner_t other_owner(input avl_owner_t o);
        return (o == OWN_IF) ? OWN_LSU : OWN_IF;
    endfunction

endpackage

// File: rtl/avl_owner_fifo.sv
// Synchronous FIFO of read owners. One entry per read accepted by the slave,
// popped when the matching response returns, so responses are routed in order.
module avl_owner_fifo
    import avl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rest,
    input  logic       push,
    input  avl_owner_t push_owner,
    input  logic       pop,
    output logic       full,
    output logic       empty,
    output avl_owner_t head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    avl_owner_t       slots [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    // Storage needs no reset: pointers and count define which slots are live.
    always_ff @(posedge clk) begin
        if (push) begin
            slots[wr_ptr] <= push_owner;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rest) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign head  = slots[rd_ptr];

endmodule

// File: rtl/avl_arb2.sv
// Two-master Avalon-MM arbiter: instruction fetch (m0) and load/store (m1)
// share one slave. Round-robin per accepted transfer; pipelined read
// responses are steered back to their issuer through an owner FIFO.
//
// Handshake: a master request (read or write) is taken by the slave in the
// cycle where that master is granted and its wait_request is 0. While
// wait_request is 1 the master must hold address, data and command stable.
// read_data_valid is a single-cycle strobe that needs no acknowledge.
module avl_arb2
    import avl_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  rest,

    input  logic [ADDR_W-1:0]     m0_address,
    input  logic [AVL_BE_W-1:0]   m0_byte_en,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [AVL_DATA_W-1:0] m0_write_data,
    output logic                  m0_wait_request,
    output logic [AVL_DATA_W-1:0] m0_read_data,
    output logic                  m0_read_data_valid,

    input  logic [ADDR_W-1:0]     m1_address,
    input  logic [AVL_BE_W-1:0]   m1_byte_en,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [AVL_DATA_W-1:0] m1_write_data,
    output logic                  m1_wait_request,
    output logic [AVL_DATA_W-1:0] m1_read_data,
    output logic                  m1_read_data_valid,

    output logic [ADDR_W-1:0]     s_address,
    output logic [AVL_BE_W-1:0]   s_byte_en,
    output logic                  s_read,
    output logic                  s_write,
    output logic [AVL_DATA_W-1:0] s_write_data,
    input  logic                  s_wait_request,
    input  logic [AVL_DATA_W-1:0] s_read_data,
    input  logic                  s_read_data_valid,

    output logic                  err_orphan
);

    avl_owner_t rr;
    avl_owner_t gnt;
    avl_owner_t head;
    logic       gnt_any;
    logic       elig0;
    logic       elig1;
    logic       sel_read;
    logic       sel_write;
    logic       accept;
    logic       push;
    logic       pop;
    logic       full;
    logic       empty;

    // Reads need a free owner slot; 'full' is registered, so a pop in the
    // same cycle cannot unblock a read (no response-to-request comb path).
    assign elig0 = m0_write | (m0_read & ~full);
    assign elig1 = m1_write | (m1_read & ~full);

    // Grant: a lone eligible master wins, a tie goes to the rr pointer.
    always_comb begin
        gnt_any = elig0 | elig1;
        gnt     = OWN_IF;
        if (elig0 && elig1) begin
            gnt = rr;
        end else if (elig1) begin
            gnt = OWN_LSU;
        end
    end

    // Slave-side mux follows the grant; m0 is passed through when idle.
    always_comb begin
        s_address    = m0_address;
        s_byte_en    = m0_byte_en;
        s_write_data = m0_write_data;
        sel_read     = m0_read;
        sel_write    = m0_write;
        if (gnt == OWN_LSU) begin
            s_address    = m1_address;
            s_byte_en    = m1_byte_en;
            s_write_data = m1_write_data;
            sel_read     = m1_read;
            sel_write    = m1_write;
        end
        s_read  = rest & gnt_any & sel_read;
        s_write = rest & gnt_any & sel_write;
    end

    // Only the granted master sees the slave stall; everyone else waits.
    always_comb begin
        m0_wait_request = ~(rest & gnt_any & (gnt == OWN_IF))  | s_wait_request;
        m1_wait_request = ~(rest & gnt_any & (gnt == OWN_LSU)) | s_wait_request;
    end

    assign accept = rest & gnt_any & ~s_wait_request;
    assign push   = accept & s_read;
    assign pop    = rest & s_read_data_valid & ~empty;

    // Round-robin pointer moves past the winner only when a transfer is taken,
    // so a stalled grant stays put while the master holds its request.
    always_ff @(posedge clk) begin
        if (!rest) begin
            rr <= OWN_IF;
        end else if (accept) begin
            rr <= other_owner(gnt);
        end
    end

    // A response with no read outstanding is dropped and flagged until reset.
    always_ff @(posedge clk) begin
        if (!rest) begin
            err_orphan <= 1'b0;
        end else if (s_read_data_valid && empty) begin
            err_orphan <= 1'b1;
        end
    end

    avl_owner_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_owner_fifo (
        .clk        (clk),
        .rest       (rest),
        .push       (push),
        .push_owner (gnt),
        .pop        (pop),
        .full       (full),
        .empty      (empty),
        .head       (head)
    );

    assign m0_read_data       = s_read_data;
    assign m1_read_data       = s_read_data;
    assign m0_read_data_valid = pop & (head == OWN_IF);
    assign m1_read_data_valid = pop & (head == OWN_LSU);

endmodule

// File: tb/tb_avl_arb2.sv
// Directed bench for avl_arb2 with a pipelined slave model.
module tb_avl_arb2;

  logic        clk = 1'b0;
  logic        rest;
  logic [31:0] m0_address, m1_address;
  logic [3:0]  m0_byte_en, m1_byte_en;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_write_data, m1_write_data;
  logic        m0_wait_request, m1_wait_request;
  logic [31:0] m0_read_data, m1_read_data;
  logic        m0_read_data_valid, m1_read_data_valid;
  logic [31:0] s_address;
  logic [3:0]  s_byte_en;
  logic        s_read, s_write;
  logic [31:0] s_write_data;
  logic        s_wait_request;
  logic [31:0] s_read_data;
  logic        s_read_data_valid;
  logic        err_orphan;

  // clock / reset
  always #5 clk = ~clk;

  avl_arb2 #(.ADDR_W(32), .OUTSTANDING(4)) dut (
    .clk(clk), .rest(rest),
    .m0_address(m0_address), .m0_byte_en(m0_byte_en), .m0_read(m0_read),
    .m0_write(m0_write), .m0_write_data(m0_write_data),
    .m0_wait_request(m0_wait_request), .m0_read_data(m0_read_data),
    .m0_read_data_valid(m0_read_data_valid),
    .m1_address(m1_address), .m1_byte_en(m1_byte_en), .m1_read(m1_read),
    .m1_write(m1_write), .m1_write_data(m1_write_data),
    .m1_wait_request(m1_wait_request), .m1_read_data(m1_read_data),
    .m1_read_data_valid(m1_read_data_valid),
    .s_address(s_address), .s_byte_en(s_byte_en), .s_read(s_read),
    .s_write(s_write), .s_write_data(s_write_data),
    .s_wait_request(s_wait_request), .s_read_data(s_read_data),
    .s_read_data_valid(s_read_data_valid),
    .err_orphan(err_orphan)
  );

  // slave model: accepts at the edge, answers in order after 'lat' cycles
  typedef struct {
    logic [31:0] d;
    int          due;
  } rsp_t;

  rsp_t        rsp_q[$];
  logic [31:0] mem [logic [31:0]];
  int          cyc = 0;
  int          lat = 2;
  logic        hold_rsp = 1'b0;
  logic        inj_rdv = 1'b0;
  logic        rdv_model = 1'b0;
  logic [31:0] rd_data = 32'h0;

  assign s_read_data_valid = rdv_model | inj_rdv;
  assign s_read_data       = rd_data;

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] slave_data(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return rd_model(a);
  endfunction

  always begin
    @(negedge clk);
    rdv_model = 1'b0;
    if (!hold_rsp && rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
      rdv_model = 1'b1;
      rd_data   = rsp_q[0].d;
      void'(rsp_q.pop_front());
    end
    #3;
    if (rest !== 1'b1) begin
      rsp_q.delete();
    end else begin
      if (s_read && !s_wait_request) rsp_q.push_back('{slave_data(s_address), cyc + lat});
      if (s_write && !s_wait_request) mem[s_address] = s_write_data;
    end
    cyc++;
  end

  // scoreboard: responses observed per master, compared to expected queues
  logic [31:0] got0[$];
  logic [31:0] got1[$];
  logic [31:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_q(input string tag, input logic [31:0] got[$]);
    chk({tag, "_n"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("%s_%0d", tag, i), got[i], exp_q[i]);
  endtask

  // driver tasks: inputs change at negedge, outputs sampled 1 ns later
  task automatic settle();
    #1;
    if (m0_read_data_valid === 1'b1) got0.push_back(m0_read_data);
    if (m1_read_data_valid === 1'b1) got1.push_back(m1_read_data);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      settle();
      @(negedge clk);
    end
  endtask

  task automatic clr_masters();
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
    m0_address = 0; m1_address = 0; m0_write_data = 0; m1_write_data = 0;
    m0_byte_en = 4'hF; m1_byte_en = 4'hF;
    s_wait_request = 0;
  endtask

  task automatic do_reset();
    rest = 0;
    clr_masters();
    idle(2);
    rest = 1;
    got0.delete();
    got1.delete();
  endtask

  initial begin
    int ok;
    rest = 0;
    clr_masters();
    @(negedge clk);
    settle();
    @(negedge clk);
    // reset values while rest=0
    m0_read = 1; m0_address = 32'h10;
    settle();
    chk("rst_m0_wait", m0_wait_request, 1);
    chk("rst_m1_wait", m1_wait_request, 1);
    chk("rst_s_read", s_read, 0);
    chk("rst_s_write", s_write, 0);
    chk("rst_m0_valid", m0_read_data_valid, 0);
    @(negedge clk);
    m0_read = 0;
    rest = 1;
    settle();
    chk("rst_err_orphan", err_orphan, 0);
    chk("idle_m0_wait", m0_wait_request, 1);
    chk("idle_s_read", s_read, 0);
    @(negedge clk);

    // 1: m0 back-to-back reads, latency 2
    do_reset(); lat = 2;
    m0_read = 1; m0_address = 32'h10;
    settle();
    chk("t1_s_read_a", s_read, 1);
    chk("t1_addr_a", s_address, 32'h10);
    chk("t1_be", s_byte_en, 4'hF);
    chk("t1_wait_a", m0_wait_request, 0);
    @(negedge clk);
    m0_address = 32'h14;
    settle();
    chk("t1_s_read_b", s_read, 1);
    chk("t1_addr_b", s_address, 32'h14);
    chk("t1_wait_b", m0_wait_request, 0);
    @(negedge clk);
    m0_read = 0;
    settle();
    chk("t1_idle", s_read, 0);
    @(negedge clk);
    idle(6);
    exp_q = '{rd_model(32'h10), rd_model(32'h14)};
    chk_q("t1_m0", got0);
    chk("t1_m1_none", got1.size(), 0);

    // 2: simultaneous requests alternate
    do_reset(); lat = 2;
    m0_read = 1; m0_address = 32'h20;
    m1_write = 1; m1_address = 32'h40; m1_write_data = 32'hDEADBEEF; m1_byte_en = 4'h3;
    settle();
    chk("t2_c1_read", s_read, 1);
    chk("t2_c1_write", s_write, 0);
    chk("t2_c1_addr", s_address, 32'h20);
    chk("t2_c1_m0w", m0_wait_request, 0);
    chk("t2_c1_m1w", m1_wait_request, 1);
    @(negedge clk);
    m0_read = 0;
    settle();
    chk("t2_c2_write", s_write, 1);
    chk("t2_c2_read", s_read, 0);
    chk("t2_c2_addr", s_address, 32'h40);
    chk("t2_c2_data", s_write_data, 32'hDEADBEEF);
    chk("t2_c2_be", s_byte_en, 4'h3);
    chk("t2_c2_m1w", m1_wait_request, 0);
    @(negedge clk);
    m0_read = 1; m0_address = 32'h24;
    m1_address = 32'h44; m1_write_data = 32'h12345678;
    settle();
    chk("t2_c3_addr", s_address, 32'h24);
    chk("t2_c3_m0w", m0_wait_request, 0);
    chk("t2_c3_m1w", m1_wait_request, 1);
    @(negedge clk);
    m0_address = 32'h28;
    settle();
    chk("t2_c4_addr", s_address, 32'h44);
    chk("t2_c4_write", s_write, 1);
    chk("t2_c4_m1w", m1_wait_request, 0);
    chk("t2_c4_m0w", m0_wait_request, 1);
    @(negedge clk);
    m1_write = 0;
    settle();
    chk("t2_c5_addr", s_address, 32'h28);
    chk("t2_c5_m0w", m0_wait_request, 0);
    @(negedge clk);
    m0_read = 0;
    m1_read = 1; m1_address = 32'h40;
    settle();
    chk("t2_c6_addr", s_address, 32'h40);
    chk("t2_c6_read", s_read, 1);
    chk("t2_c6_m1w", m1_wait_request, 0);
    @(negedge clk);
    m1_read = 0;
    idle(6);
    exp_q = '{rd_model(32'h20), rd_model(32'h24), rd_model(32'h28)};
    chk_q("t2_m0", got0);
    exp_q = '{32'hDEADBEEF};
    chk_q("t2_m1", got1);

    // 3: slave stall holds grant and rr
    do_reset(); lat = 2;
    m0_write = 1; m0_address = 32'h300; m0_write_data = 32'h1;
    settle();
    chk("t3_pre_m0w", m0_wait_request, 0);
    @(negedge clk);
    m0_write = 0;
    m0_read = 1; m0_address = 32'h84;
    m1_read = 1; m1_address = 32'h80;
    s_wait_request = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk($sformatf("t3_st%0d_addr", i), s_address, 32'h80);
      chk($sformatf("t3_st%0d_read", i), s_read, 1);
      chk($sformatf("t3_st%0d_m1w", i), m1_wait_request, 1);
      chk($sformatf("t3_st%0d_m0w", i), m0_wait_request, 1);
      @(negedge clk);
    end
    s_wait_request = 0;
    settle();
    chk("t3_acc_addr", s_address, 32'h80);
    chk("t3_acc_m1w", m1_wait_request, 0);
    chk("t3_acc_m0w", m0_wait_request, 1);
    @(negedge clk);
    m1_read = 0;
    settle();
    chk("t3_m0_addr", s_address, 32'h84);
    chk("t3_m0_read", s_read, 1);
    chk("t3_m0_m0w", m0_wait_request, 0);
    @(negedge clk);
    m0_read = 0;
    idle(6);
    exp_q = '{rd_model(32'h84)};
    chk_q("t3_m0", got0);
    exp_q = '{rd_model(32'h80)};
    chk_q("t3_m1", got1);

    // 4: interleaved reads, owner FIFO fills at 4 outstanding
    do_reset(); lat = 3; hold_rsp = 1;
    m0_read = 1; m0_address = 32'h0;
    settle();
    chk("t4_r0_m0w", m0_wait_request, 0);
    @(negedge clk);
    m0_read = 0; m1_read = 1; m1_address = 32'h100;
    settle();
    chk("t4_r1_addr", s_address, 32'h100);
    chk("t4_r1_m1w", m1_wait_request, 0);
    @(negedge clk);
    m1_read = 0; m0_read = 1; m0_address = 32'h4;
    settle();
    chk("t4_r2_m0w", m0_wait_request, 0);
    @(negedge clk);
    m0_read = 0; m1_read = 1; m1_address = 32'h104;
    settle();
    chk("t4_r3_m1w", m1_wait_request, 0);
    @(negedge clk);
    m1_read = 0; m0_read = 1; m0_address = 32'h8;
    settle();
    chk("t4_full_read", s_read, 0);
    chk("t4_full_m0w", m0_wait_request, 1);
    @(negedge clk);
    m1_write = 1; m1_address = 32'h200; m1_write_data = 32'hCAFEF00D;
    settle();
    chk("t4_wr_write", s_write, 1);
    chk("t4_wr_read", s_read, 0);
    chk("t4_wr_addr", s_address, 32'h200);
    chk("t4_wr_m1w", m1_wait_request, 0);
    chk("t4_wr_m0w", m0_wait_request, 1);
    @(negedge clk);
    m1_write = 0;
    hold_rsp = 0;
    ok = 0;
    for (int n = 0; n < 10 && ok == 0; n++) begin
      settle();
      if (m0_wait_request === 1'b0) ok = 1;
      @(negedge clk);
    end
    m0_read = 0;
    chk("t4_acc_after_pop", ok, 1);
    idle(10);
    exp_q = '{rd_model(32'h0), rd_model(32'h4), rd_model(32'h8)};
    chk_q("t4_m0", got0);
    exp_q = '{rd_model(32'h100), rd_model(32'h104)};
    chk_q("t4_m1", got1);
    chk("t4_no_orphan", err_orphan, 0);

    // 5: orphan response is sticky until reset
    do_reset();
    inj_rdv = 1;
    settle();
    chk("t5_pre_err", err_orphan, 0);
    chk("t5_m0_valid", m0_read_data_valid, 0);
    chk("t5_m1_valid", m1_read_data_valid, 0);
    @(negedge clk);
    inj_rdv = 0;
    settle();
    chk("t5_err_set", err_orphan, 1);
    @(negedge clk);
    settle();
    chk("t5_err_sticky", err_orphan, 1);
    @(negedge clk);
    rest = 0;
    settle();
    chk("t5_rst_m0w", m0_wait_request, 1);
    @(negedge clk);
    rest = 1;
    settle();
    chk("t5_err_clr", err_orphan, 0);
    @(negedge clk);

    // 6: reset with reads in flight discards owners
    do_reset(); lat = 4;
    m1_read = 1; m1_address = 32'h20;
    settle();
    chk("t6_r0_m1w", m1_wait_request, 0);
    @(negedge clk);
    m1_read = 0; m0_read = 1; m0_address = 32'h10;
    settle();
    chk("t6_r1_m0w", m0_wait_request, 0);
    @(negedge clk);
    m0_address = 32'h30;
    rest = 0;
    settle();
    chk("t6_rst_read", s_read, 0);
    chk("t6_rst_m0w", m0_wait_request, 1);
    chk("t6_rst_m1w", m1_wait_request, 1);
    @(negedge clk);
    rest = 1; m0_read = 0;
    settle();
    chk("t6_err", err_orphan, 0);
    chk("t6_idle_read", s_read, 0);
    @(negedge clk);
    got0.delete();
    got1.delete();
    m0_read = 1; m0_address = 32'h10;
    settle();
    chk("t6_new_m0w", m0_wait_request, 0);
    @(negedge clk);
    m0_read = 0;
    idle(8);
    exp_q = '{rd_model(32'h10)};
    chk_q("t6_m0", got0);
    chk("t6_m1_none", got1.size(), 0);
    chk("t6_err_end", err_orphan, 0);

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
